// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream handshake bundle carrying tdata/tlast, shared by the FIFO's
// upstream (slave) and downstream (master) sides.
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with tlast transport, optional packet-gated output,
// arbitrary depth, fill level, packet count and almost-full/empty flags.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = FIFO_DEPTH - 1,
  parameter int AE_THRESH   = 1,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_pkt_fifo_if.slave       s_axis,
  axis_pkt_fifo_if.master      m_axis,
  output logic [LW-1:0]        level,
  output logic [LW-1:0]        pkt_count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 oversize
);

  localparam int            PW     = $clog2(FIFO_DEPTH);
  localparam bit            PM     = (PACKET_MODE != 0);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] L_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] L_AE   = LW'(AE_THRESH);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [LW-1:0] L_ZERO = LW'(0);

  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [LW-1:0]       r_pkt_count;
  logic                r_oversize;
  logic                r_af;
  logic                r_ae;

  logic [DATA_WIDTH:0] w_head;
  logic [LW-1:0]       w_level_nxt;
  logic [LW-1:0]       w_pkt_nxt;
  logic                w_full;
  logic                w_empty;
  logic                w_tready;
  logic                w_tvalid;
  logic                w_push;
  logic                w_pop;
  logic                w_push_last;
  logic                w_pop_last;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(FIFO_DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign w_full      = (r_level == L_FULL);
  assign w_empty     = (r_level == L_ZERO);
  assign w_tready    = ~rst & ~w_full;
  assign w_tvalid    = PM ? (~w_empty & ((r_pkt_count != L_ZERO) | r_oversize)) : ~w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_push      = s_axis.tvalid & w_tready;
  assign w_pop       = w_tvalid & m_axis.tready;
  assign w_push_last = w_push & s_axis.tlast;
  assign w_pop_last  = w_pop & w_head[DATA_WIDTH];

  assign s_axis.tready = w_tready;
  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_head[DATA_WIDTH-1:0];
  assign m_axis.tlast  = w_head[DATA_WIDTH];
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;
  assign almost_full   = r_af;
  assign almost_empty  = r_ae;
  assign oversize      = r_oversize;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + L_ONE;
      2'b01:   w_level_nxt = r_level - L_ONE;
      default: w_level_nxt = r_level;
    endcase
    w_pkt_nxt = r_pkt_count;
    case ({w_push_last, w_pop_last})
      2'b10:   w_pkt_nxt = r_pkt_count + L_ONE;
      2'b01:   w_pkt_nxt = r_pkt_count - L_ONE;
      default: w_pkt_nxt = r_pkt_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= PW'(0);
      r_rd_ptr    <= PW'(0);
      r_level     <= L_ZERO;
      r_pkt_count <= L_ZERO;
      r_oversize  <= 1'b0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_level     <= w_level_nxt;
      r_pkt_count <= w_pkt_nxt;
      r_af        <= (w_level_nxt >= L_AF);
      r_ae        <= (w_level_nxt <= L_AE);
      // A full FIFO with no complete packet would deadlock; release it cut-through.
      if (w_pop_last) begin
        r_oversize <= 1'b0;
      end else if (PM && w_full && (r_pkt_count == L_ZERO)) begin
        r_oversize <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised AXI-Stream FIFO for the I2C master datapath, next generation of the plain AXIS FIFO. Adds `tlast` transport and optional packet mode, where output is held until a complete packet is stored. Also supports arbitrary (non-power-of-two) depth, a fill level output and programmable almost-full/almost-empty flags. Sits between the command/data source and the I2C engine so that a full I2C transaction is buffered before the bus is started.

## Interface
- `DATA_WIDTH`, 16, width of `tdata`.
- `FIFO_DEPTH`, 4, entry count; any integer ≥ 2, not restricted to powers of two.
- `PACKET_MODE`, 0; 0 = stream mode, 1 = output gated on complete packets.
- `AF_THRESH`, FIFO_DEPTH-1; `almost_full` asserts when level ≥ AF_THRESH.
- `AE_THRESH`, 1; `almost_empty` asserts when level ≤ AE_THRESH.
- Derived: `LW = $clog2(FIFO_DEPTH+1)`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  write data.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tvalid`  in  1  write request.
- `s_axis_tready`  out  1  space available.
- `m_axis_tdata`  out  DATA_WIDTH  head entry data.
- `m_axis_tlast`  out  1  head entry `tlast`.
- `m_axis_tvalid`  out  1  head entry readable.
- `m_axis_tready`  in  1  downstream accepts.
- `level`  out  LW  entries stored.
- `pkt_count`  out  LW  complete packets (stored `tlast` beats) in FIFO.
- `almost_full`  out  1  level ≥ AF_THRESH.
- `almost_empty`  out  1  level ≤ AE_THRESH.
- `oversize`  out  1  packet-mode release of a packet larger than the FIFO is in progress.

## Operation
- Storage: DATA_WIDTH+1 bits per entry (`tdata`, `tlast`). `wr_ptr`/`rd_ptr` wrap from FIFO_DEPTH-1 to 0 explicitly, not by overflow.
- push = `s_axis_tvalid & s_axis_tready`; pop = `m_axis_tvalid & m_axis_tready`.
- `s_axis_tready = !rst & (level != FIFO_DEPTH)`, derived from registered state only. A full FIFO does not accept a write in the same cycle as a pop; this avoids a ready/valid combinational loop.
- `level` update: push only → +1; pop only → −1; both or neither → unchanged.
- `pkt_count` update: push with `tlast` → +1; pop with `tlast` → −1; both in the same cycle → unchanged.
- Stream mode (PACKET_MODE=0): `m_axis_tvalid = (level != 0)`; `tlast` is passed through but never gates output.
- Packet mode (PACKET_MODE=1): `m_axis_tvalid = (level != 0) & ((pkt_count != 0) | oversize)`.
- `oversize` register (packet mode only; stuck at 0 in stream mode):
  - Set when level == FIFO_DEPTH and pkt_count == 0, i.e. deadlock would otherwise occur.
  - Cleared on pop of a beat with `tlast`=1.
  - While set, beats drain cut-through, including beats still arriving.
- `m_axis_tdata`/`m_axis_tlast` are read asynchronously from the entry at `rd_ptr`. Their value is don't-care while `m_axis_tvalid`=0.
- Upstream must hold `tdata`/`tlast` stable while `tvalid`=1 and `tready`=0. The FIFO never deasserts `m_axis_tvalid` without a pop, except on `rst`.

## Timing
- Reset (`rst`=1 at a rising edge):
  - Pointers, `level`, `pkt_count` and `oversize` go to 0.
  - `s_axis_tready`=0 while `rst` is high, then 1 in the first cycle after release.
  - `m_axis_tvalid`=0, `almost_empty`=1 (for AE_THRESH ≥ 0), `almost_full`=0.
  - Stored contents are discarded; a reset mid-packet drops the partial packet with no output.
- Write-to-read latency is 1 cycle: a push at edge N gives `m_axis_tvalid`=1 after edge N in stream mode.
- In packet mode, `m_axis_tvalid` rises 1 cycle after the `tlast` beat is pushed.
- Throughput: 1 beat/cycle in and out simultaneously whenever 0 < level < FIFO_DEPTH.
- `level`, `pkt_count` and the flags are registered; they reflect all pushes/pops up to the previous edge.
- `oversize` sets the edge after the full/no-packet condition is seen; `m_axis_tvalid` rises in that following cycle.

## Test plan
- Reset and stream fill: DEPTH=5, PACKET_MODE=0. Push 5 beats 0x0001..0x0005 with `m_axis_tready`=0 → `s_axis_tready`=0 and `level`=5. Then drain → data comes out in order with one beat per cycle; `level` returns to 0.
- Wrap-around and concurrent traffic: DEPTH=5, continuous push/pop of 20 beats with the FIFO held at level 2 → no loss or reorder across pointer wrap; `level` stays at 2.
- Packet gating: PACKET_MODE=1. Push 3 beats with `tlast` on the third → `m_axis_tvalid` stays 0 until the cycle after the third push. `pkt_count` steps 0→1, then back to 0 after the `tlast` pop.
- Simultaneous tlast events: a push with `tlast` and a pop with `tlast` in the same cycle → `pkt_count` unchanged and `m_axis_tvalid` stays continuous.
- Oversize: DEPTH=4, PACKET_MODE=1. Push a 6-beat packet → `oversize`=1 when level=4, then all 6 beats drain in order. `oversize` clears on the `tlast` pop.
- Flags and mid-operation reset:
  - AF_THRESH=3, AE_THRESH=1 → `almost_full` is 1 exactly at level ≥ 3; `almost_empty` is 1 at level ≤ 1.
  - Assert `rst` with level=3 → next cycle `level`=0 and `m_axis_tvalid`=0; previously stored data never appears.
